// File: rtl/alert_pulse_stretcher.sv
// rtl/alert_pulse_stretcher.sv - turns a one-cycle alert request into timed on/off bursts
//
// Purpose: on Trig_in, drive Alert_out for REPEATS bursts of ON_CYCLES cycles
// separated by OFF_CYCLES gaps. Ack_in cancels a running pattern.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst        in   synchronous active-high reset
//   Trig_in    in   one-cycle alert request (ignored while busy)
//   Ack_in     in   one-cycle acknowledge (ignored while idle)
//   Alert_out  out  buzzer/LED drive, high during on-bursts
//   Busy_out   out  high while a pattern is in progress
//   Done_out   out  one-cycle pulse after natural completion
//   Acked_out  out  one-cycle pulse after cancellation by Ack_in
module alert_pulse_stretcher #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 4,
  parameter int REPEATS    = 3,
  parameter int CNT_W      = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Trig_in,
  input  logic Ack_in,
  output logic Alert_out,
  output logic Busy_out,
  output logic Done_out,
  output logic Acked_out
);

  typedef enum logic [1:0] {
    S_Idle = 2'd0,
    S_On   = 2'd1,
    S_Off  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEATS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rep, rep_n;
  logic             done_n, acked_n;

  // State register; Done_out/Acked_out are registered so they land in the
  // first idle cycle after the terminating transition.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_Idle;
      cnt       <= '0;
      rep       <= '0;
      Done_out  <= 1'b0;
      Acked_out <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rep       <= rep_n;
      Done_out  <= done_n;
      Acked_out <= acked_n;
    end
  end

  // Next-state logic. Ack outranks terminal count; terminal compares are
  // evaluated before any increment so counters never wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rep_n   = rep;
    done_n  = 1'b0;
    acked_n = 1'b0;
    case (state)
      S_Idle: begin
        if (Trig_in) begin
          state_n = S_On;
          cnt_n   = '0;
          rep_n   = '0;
        end
      end
      S_On: begin
        if (Ack_in) begin
          state_n = S_Idle;
          acked_n = 1'b1;
        end else if (cnt == ON_LAST && rep == REP_LAST) begin
          state_n = S_Idle;
          done_n  = 1'b1;
        end else if (cnt == ON_LAST) begin
          state_n = S_Off;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_Off: begin
        if (Ack_in) begin
          state_n = S_Idle;
          acked_n = 1'b1;
        end else if (cnt == OFF_LAST) begin
          state_n = S_On;
          cnt_n   = '0;
          rep_n   = rep + ONE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = S_Idle;
        cnt_n   = '0;
        rep_n   = '0;
      end
    endcase
  end

  // Moore outputs.
  always_comb begin
    Alert_out = 1'b0;
    Busy_out  = 1'b0;
    case (state)
      S_On: begin
        Alert_out = 1'b1;
        Busy_out  = 1'b1;
      end
      S_Off: begin
        Busy_out = 1'b1;
      end
      default: begin
        Alert_out = 1'b0;
        Busy_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alert_pulse_stretcher.sv
// tb/tb_alert_pulse_stretcher.sv - randomized and directed check against a pattern-position model
module tb_alert_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       ack;
  logic [1:0] alert_o, busy_o, done_o, acked_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: default parameters. Instance 1: degenerate 1/1/1.
  int on_c [2] = '{4, 1};
  int off_c[2] = '{4, 1};
  int rep_c[2] = '{3, 1};

  // Model: a pattern is just a position within its total length.
  bit m_active[2];
  int m_pos   [2];
  bit m_done  [2];
  bit m_acked [2];

  always #5 clk = ~clk;

  alert_pulse_stretcher u_dut (
    .Clk(clk), .Rst(rst), .Trig_in(trig), .Ack_in(ack),
    .Alert_out(alert_o[0]), .Busy_out(busy_o[0]),
    .Done_out(done_o[0]), .Acked_out(acked_o[0])
  );

  alert_pulse_stretcher #(.ON_CYCLES(1), .OFF_CYCLES(1), .REPEATS(1), .CNT_W(16)) u_deg (
    .Clk(clk), .Rst(rst), .Trig_in(trig), .Ack_in(ack),
    .Alert_out(alert_o[1]), .Busy_out(busy_o[1]),
    .Done_out(done_o[1]), .Acked_out(acked_o[1])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit t, input bit a, input bit r);
    int len;
    len = rep_c[i] * on_c[i] + (rep_c[i] - 1) * off_c[i];
    m_done[i]  = 1'b0;
    m_acked[i] = 1'b0;
    if (r) begin
      m_active[i] = 1'b0;
    end else if (!m_active[i]) begin
      if (t) begin
        m_active[i] = 1'b1;
        m_pos[i]    = 0;
      end
    end else if (a) begin
      m_active[i] = 1'b0;
      m_acked[i]  = 1'b1;
    end else if (m_pos[i] == len - 1) begin
      m_active[i] = 1'b0;
      m_done[i]   = 1'b1;
    end else begin
      m_pos[i]++;
    end
  endtask

  function automatic bit exp_alert(input int i);
    return m_active[i] && ((m_pos[i] % (on_c[i] + off_c[i])) < on_c[i]);
  endfunction

  // Called at a negedge: apply inputs, clock once, compare at next negedge.
  task automatic cycle(input bit t, input bit a, input bit r);
    trig = t;
    ack  = a;
    rst  = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, t, a, r);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("alert%0d", i), int'(alert_o[i]), int'(exp_alert(i)));
      check($sformatf("busy%0d", i),  int'(busy_o[i]),  int'(m_active[i]));
      check($sformatf("done%0d", i),  int'(done_o[i]),  int'(m_done[i]));
      check($sformatf("acked%0d", i), int'(acked_o[i]), int'(m_acked[i]));
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int busy_cnt, alert_cnt, done_at, acked_seen;
    trig = 1'b0;
    ack  = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    do_reset();
    check("reset_alert", int'(alert_o[0]), 0);
    check("reset_busy",  int'(busy_o[0]),  0);
    check("reset_done",  int'(done_o[0]),  0);
    check("reset_acked", int'(acked_o[0]), 0);

    // Full pattern, with retriggers at 10 and 20 ignored; retrigger at 21 accepted.
    busy_cnt = 0; alert_cnt = 0; done_at = -1; acked_seen = 0;
    for (int c = 0; c <= 22; c++) begin
      cycle(c == 0 || c == 10 || c == 20 || c == 21, 1'b0, 1'b0);
      if (c + 1 <= 21) begin
        busy_cnt  += int'(busy_o[0]);
        alert_cnt += int'(alert_o[0]);
        if (done_o[0]) done_at = c + 1;
        acked_seen += int'(acked_o[0]);
      end
    end
    check("full_busy_len",  busy_cnt,  20);
    check("full_alert_len", alert_cnt, 12);
    check("full_done_at",   done_at,   21);
    check("full_no_ack",    acked_seen, 0);
    check("retrig_alert",   int'(alert_o[0]), 1);
    do_reset();

    // Ack during a gap.
    for (int c = 0; c <= 8; c++) cycle(c == 0, c == 6, 1'b0);
    do_reset();

    // Ack vs expiry tie at 20.
    for (int c = 0; c <= 22; c++) begin
      cycle(c == 0, c == 20, 1'b0);
      if (c == 20) begin
        check("tie_acked", int'(acked_o[0]), 1);
        check("tie_done",  int'(done_o[0]),  0);
      end
    end
    // Ack at 2 during first burst; idle ack afterwards.
    for (int c = 0; c <= 6; c++) cycle(c == 0, c == 2 || c == 5, 1'b0);
    do_reset();

    // Reset mid-pattern with simultaneous ack, then fresh trigger at 12.
    for (int c = 0; c <= 14; c++) begin
      cycle(c == 0 || c == 12, c == 10, c == 10);
      if (c == 10) check("rst_no_acked", int'(acked_o[0]), 0);
      if (c == 12) check("rst_retrig",   int'(alert_o[0]), 1);
    end
    do_reset();

    // Degenerate instance: alert in cycle 1 only, done in cycle 2.
    cycle(1'b1, 1'b0, 1'b0);
    check("deg_alert1", int'(alert_o[1]), 1);
    cycle(1'b0, 1'b0, 1'b0);
    check("deg_done2",  int'(done_o[1]), 1);
    check("deg_alert2", int'(alert_o[1]), 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alert_pulse_stretcher.md
# alert_pulse_stretcher

Turns a single-cycle reminder event into a timed, user-visible alert pattern on the buzzer/LED drive. It repeats a fixed number of on/off bursts until the pattern finishes or the user acknowledges. The acknowledge input is the one-cycle pulse produced by the Enter button shaper. Together the two blocks close the user loop: the button shaper converts a held level into a one-cycle pulse, and this block converts a pulse into held levels.

## Interface

- ON_CYCLES, default 4: clock cycles per alert-on burst; must be ≥1.
- OFF_CYCLES, default 4: clock cycles per gap between bursts; must be ≥1.
- REPEATS, default 3: number of on-bursts per alert; must be ≥1.
- CNT_W, default 16: phase/repeat counter width; must hold max(ON_CYCLES, OFF_CYCLES, REPEATS)−1.

Ports (one clock; reset is synchronous and active-high):

- Clk  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- Trig_in  in  1  one-cycle alert request from the reminder scheduler.
- Ack_in  in  1  one-cycle acknowledge from the Enter button shaper.
- Alert_out  out  1  buzzer/LED drive; high during on-bursts.
- Busy_out  out  1  high whenever a pattern is in progress.
- Done_out  out  1  one-cycle pulse when the pattern completes without an acknowledge.
- Acked_out  out  1  one-cycle pulse when the pattern is cancelled by an acknowledge.

## Operation

- States: S_Idle, S_On, S_Off. A phase counter `cnt` and a repeat counter `rep` are both CNT_W bits.
- Outputs are Moore:
  - Alert_out = (State == S_On)
  - Busy_out = (State != S_Idle)
- Done_out and Acked_out are registered. Each is high only in the first S_Idle cycle after its terminating transition.
- S_Idle:
  - Trig_in = 1 → S_On, cnt = 0, rep = 0.
  - Ack_in is ignored.
  - If Trig_in and Ack_in are both high, Trig_in wins.
- S_On, checked in this priority order:
  1. Ack_in = 1 → S_Idle, assert Acked_out.
  2. cnt == ON_CYCLES−1 and rep == REPEATS−1 → S_Idle, assert Done_out.
  3. cnt == ON_CYCLES−1 → S_Off, cnt = 0.
  4. Otherwise cnt += 1.
- S_Off, checked in this priority order:
  1. Ack_in = 1 → S_Idle, assert Acked_out.
  2. cnt == OFF_CYCLES−1 → S_On, cnt = 0, rep += 1.
  3. Otherwise cnt += 1.
- Trig_in while Busy_out is high is ignored: no restart, no queuing.
- Ack_in has priority over counter expiry. If both happen in the same cycle, Acked_out fires and Done_out does not.
- Counters never wrap. Terminal-count compares precede any increment.
- Default case (illegal state encoding) → S_Idle with all outputs 0.
- Rst = 1 in any cycle overrides everything, including a same-cycle Trig_in or Ack_in. The next state is S_Idle with cnt = rep = 0 and all outputs 0.

## Timing

- Reset values: Alert_out = 0, Busy_out = 0, Done_out = 0, Acked_out = 0.
- Latency: Trig_in high in cycle t → Alert_out and Busy_out high from cycle t+1.
- Pattern length: Busy_out stays high for REPEATS·ON_CYCLES + (REPEATS−1)·OFF_CYCLES cycles.
- Completion: Done_out fires in the cycle right after the last on-cycle, and Busy_out is low in that same cycle.
- Acknowledge: Ack_in high in cycle a while busy → Alert_out and Busy_out low and Acked_out high in cycle a+1.
- Back-to-back: a new Trig_in is accepted in the same cycle that Done_out or Acked_out is high, because the state is S_Idle then.
- Degenerate parameters: ON_CYCLES = 1 gives one-cycle bursts. REPEATS = 1 gives no S_Off visit.

## Test plan

All scenarios use default parameters.

- **Full pattern:** reset, then Trig_in at cycle 0 →
  - Alert_out high in cycles 1–4, 9–12 and 17–20, low in 5–8 and 13–16.
  - Busy_out high in cycles 1–20.
  - Done_out high only in cycle 21; Acked_out stays 0.
- **Ack during a gap:** Trig_in at 0, Ack_in at 6 (S_Off) → Busy_out low from 7, Acked_out high in 7 only, Alert_out stays 0, no Done_out.
- **Ack vs expiry tie:** Trig_in at 0, Ack_in at 20 → Acked_out high at 21, Done_out stays 0. Separately, Ack_in at 2 → Alert_out high in cycles 1–2 only.
- **Retrigger and idle ack:**
  - Trig_in at 0, 10 and 20 → a single pattern identical to the full-pattern scenario.
  - A further Trig_in at 21 → Alert_out high from 22.
  - Ack_in while idle → no output change.
- **Reset mid-pattern:** Trig_in at 0, Rst at 10 together with Ack_in → all outputs 0 at 11, no Acked_out. Trig_in at 12 starts a fresh pattern with Alert_out high from 13.
- **Degenerate parameters:** ON_CYCLES = 1, OFF_CYCLES = 1, REPEATS = 1, Trig_in at 0 → Alert_out high in cycle 1 only, Done_out high in cycle 2.
